operand_capture: RTL and testbench

OPERAND_CAPTURE -- requirements
Module: operand_capture

---
 rtl/operand_capture.sv | 157 +++++++++++++++
 tb/tb_operand_capture.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/operand_capture.sv
// Operand capture front end for a 4-bit subtractor.
// Synchronizes switches and buttons, debounces buttons, runs a 3-phase load FSM.
module operand_capture #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] Sw,
  input  logic       Btn0,
  input  logic       Btn1,
  output logic [3:0] OpX,
  output logic [3:0] OpY,
  output logic       Bin,
  output logic       OpValid,
  output logic [1:0] Phase
);

  typedef enum logic [1:0] {
    LOAD_X = 2'd0,
    LOAD_Y = 2'd1,
    READY  = 2'd2
  } state_t;

  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

  // index 0 is the clear button, index 1 the enter button
  logic [1:0]  btn_raw;
  logic [7:0]  sw_s1_q, sw_s2_q;
  logic [1:0]  btn_s1_q, btn_s2_q;
  logic [15:0] cnt_q [2];
  logic [15:0] cnt_d [2];
  logic [1:0]  lvl_q, lvl_d;
  logic [1:0]  pulse_q, pulse_d;

  state_t      state_q, state_d;
  logic [3:0]  opx_q, opx_d;
  logic [3:0]  opy_q, opy_d;
  logic        bin_q, bin_d;
  logic        valid_q, valid_d;

  logic        unused_sw;

  assign btn_raw   = {Btn1, Btn0};
  assign unused_sw = ^sw_s2_q[7:5];

  // two-flop synchronizers for every asynchronous input
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      btn_s1_q <= '0;
      btn_s2_q <= '0;
    end else begin
      sw_s1_q  <= Sw;
      sw_s2_q  <= sw_s1_q;
      btn_s1_q <= btn_raw;
      btn_s2_q <= btn_s1_q;
    end
  end

  // debounce: count clocks the sample disagrees with the level, flip on terminal count
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_d[i]   = cnt_q[i];
      lvl_d[i]   = lvl_q[i];
      pulse_d[i] = 1'b0;
      if (btn_s2_q[i] == lvl_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        cnt_d[i]   = '0;
        lvl_d[i]   = ~lvl_q[i];
        pulse_d[i] = ~lvl_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  // debouncer state and one-clock press pulses
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= '0;
      end
      lvl_q   <= '0;
      pulse_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      lvl_q   <= lvl_d;
      pulse_q <= pulse_d;
    end
  end

  // load sequencer; clear pulse overrides enter pulse
  always_comb begin
    state_d = state_q;
    opx_d   = opx_q;
    opy_d   = opy_q;
    bin_d   = bin_q;
    valid_d = valid_q;
    if (pulse_q[0]) begin
      state_d = LOAD_X;
      opx_d   = '0;
      opy_d   = '0;
      bin_d   = 1'b0;
      valid_d = 1'b0;
    end else if (pulse_q[1]) begin
      unique case (state_q)
        LOAD_X: begin
          opx_d   = sw_s2_q[3:0];
          valid_d = 1'b0;
          state_d = LOAD_Y;
        end
        LOAD_Y: begin
          opy_d   = sw_s2_q[3:0];
          bin_d   = sw_s2_q[4];
          valid_d = 1'b1;
          state_d = READY;
        end
        READY: begin
          valid_d = 1'b0;
          state_d = LOAD_X;
        end
        default: begin
          valid_d = 1'b0;
          state_d = LOAD_X;
        end
      endcase
    end
  end

  // sequencer and operand registers
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= LOAD_X;
      opx_q   <= '0;
      opy_q   <= '0;
      bin_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      opx_q   <= opx_d;
      opy_q   <= opy_d;
      bin_q   <= bin_d;
      valid_q <= valid_d;
    end
  end

  assign OpX     = opx_q;
  assign OpY     = opy_q;
  assign Bin     = bin_q;
  assign OpValid = valid_q;
  assign Phase   = state_q;

endmodule

// File: tb/tb_operand_capture.sv
// Directed bench for operand_capture with a short debounce window.
// Vector table for load sequences plus hand-written corner sequences.
module tb_operand_capture;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [7:0] Sw = '0;
  logic       Btn0 = 1'b0;
  logic       Btn1 = 1'b0;
  logic [3:0] OpX, OpY;
  logic       Bin, OpValid;
  logic [1:0] Phase;

  int n_vec = 0;
  int n_bad = 0;

  operand_capture #(.DEBOUNCE_CYCLES(4)) dut (
    .Clk(Clk), .Rst(Rst), .Sw(Sw), .Btn0(Btn0), .Btn1(Btn1),
    .OpX(OpX), .OpY(OpY), .Bin(Bin), .OpValid(OpValid), .Phase(Phase)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] sw_x;
    logic [7:0] sw_y;
    logic [3:0] x;
    logic [3:0] y;
    logic       b;
  } vec_t;

  vec_t vt [5];

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic press(input logic [1:0] which, input logic [7:0] sw);
    Sw   = sw;
    Btn0 = which[0];
    Btn1 = which[1];
    step(10);
    Btn0 = 1'b0;
    Btn1 = 1'b0;
    step(10);
  endtask

  task automatic check_all(input string tag, input logic [3:0] x,
                           input logic [3:0] y, input logic b,
                           input logic v, input logic [1:0] p);
    check({tag, ".opx"}, {4'h0, OpX}, {4'h0, x});
    check({tag, ".opy"}, {4'h0, OpY}, {4'h0, y});
    check({tag, ".bin"}, {7'h0, Bin}, {7'h0, b});
    check({tag, ".valid"}, {7'h0, OpValid}, {7'h0, v});
    check({tag, ".phase"}, {6'h0, Phase}, {6'h0, p});
  endtask

  initial begin
    int bad_cycles;
    vt[0] = '{8'h05, 8'h13, 4'h5, 4'h3, 1'b1};
    vt[1] = '{8'hFA, 8'hEF, 4'hA, 4'hF, 1'b0};
    vt[2] = '{8'h1F, 8'h10, 4'hF, 4'h0, 1'b1};
    vt[3] = '{8'h00, 8'h1F, 4'h0, 4'hF, 1'b1};
    vt[4] = '{8'hE6, 8'h09, 4'h6, 4'h9, 1'b0};

    #2;
    check_all("reset", 4'h0, 4'h0, 1'b0, 1'b0, 2'd0);
    step(2);
    Rst = 1'b0;
    step(2);
    check_all("post_reset", 4'h0, 4'h0, 1'b0, 1'b0, 2'd0);

    // load sequences from the table
    for (int i = 0; i < 5; i++) begin
      press(2'b01, 8'h00);
      check_all($sformatf("v%0d.clr", i), 4'h0, 4'h0, 1'b0, 1'b0, 2'd0);
      press(2'b10, vt[i].sw_x);
      check_all($sformatf("v%0d.x", i), vt[i].x, 4'h0, 1'b0, 1'b0, 2'd1);
      press(2'b10, vt[i].sw_y);
      check_all($sformatf("v%0d.y", i), vt[i].x, vt[i].y, vt[i].b,
                1'b1, 2'd2);
      press(2'b10, 8'h00);
      check_all($sformatf("v%0d.rdy", i), vt[i].x, vt[i].y, vt[i].b,
                1'b0, 2'd0);
    end

    // bounce shorter than the window yields nothing (starts in READY)
    press(2'b01, 8'h00);
    press(2'b10, 8'h07);
    press(2'b10, 8'h12);
    Sw = 8'h0B;
    repeat (10) begin
      Btn1 = ~Btn1;
      step(2);
    end
    Btn1 = 1'b0;
    step(12);
    check_all("bounce", 4'h7, 4'h2, 1'b1, 1'b1, 2'd2);

    // long hold from LOAD_X captures once
    press(2'b01, 8'h00);
    Sw = 8'h0D;
    Btn1 = 1'b1;
    bad_cycles = 0;
    repeat (100) begin
      step(1);
      if (Phase == 2'd2) bad_cycles++;
    end
    Btn1 = 1'b0;
    step(10);
    check("hold.ready_cycles", 8'(bad_cycles), 8'd0);
    check_all("hold", 4'hD, 4'h0, 1'b0, 1'b0, 2'd1);

    // simultaneous clear and enter in READY: clear wins
    press(2'b10, 8'h1E);
    check_all("both.pre", 4'hD, 4'hE, 1'b1, 1'b1, 2'd2);
    press(2'b11, 8'h15);
    check_all("both", 4'h0, 4'h0, 1'b0, 1'b0, 2'd0);

    // asynchronous reset during LOAD_Y
    press(2'b10, 8'h09);
    check_all("arst.pre", 4'h9, 4'h0, 1'b0, 1'b0, 2'd1);
    @(posedge Clk);
    #2 Rst = 1'b1;
    #1;
    check_all("arst", 4'h0, 4'h0, 1'b0, 1'b0, 2'd0);
    step(2);
    Rst = 1'b0;
    step(2);

    // reset mid-debounce; held button then debounces as a fresh press
    Sw = 8'h07;
    Btn1 = 1'b1;
    step(4);
    Rst = 1'b1;
    step(2);
    Rst = 1'b0;
    step(6);
    check("held.latency_early", {6'h0, Phase}, 8'd0);
    step(1);
    check("held.latency", {6'h0, Phase}, 8'd1);
    step(20);
    Btn1 = 1'b0;
    step(10);
    check_all("held", 4'h7, 4'h0, 1'b0, 1'b0, 2'd1);

    // switch sweep in READY leaves operands alone
    press(2'b01, 8'h00);
    press(2'b10, 8'h0C);
    press(2'b10, 8'h16);
    bad_cycles = 0;
    for (int s = 0; s < 256; s++) begin
      Sw = 8'(s);
      step(1);
      if (OpX !== 4'hC || OpY !== 4'h6 || Bin !== 1'b1 ||
          Phase !== 2'd2)
        bad_cycles++;
    end
    check("sweep.changes", 8'(bad_cycles), 8'd0);
    press(2'b10, 8'hFF);
    check_all("sweep", 4'hC, 4'h6, 1'b1, 1'b0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
